uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter byte port.
// One-entry output register, burst-limited fairness, registered one-hot grant.
module uart_tx_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state_q, state_d, other_state;
  logic [1:0]    grant_q;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          last_q, last_d;
  logic          out_free, hs0, hs1;
  logic          own_id, own_valid, other_valid, own_hs;

  // The output register can take a new byte when empty or draining this cycle.
  assign out_free   = !tx_valid_q || tx_ready;
  assign req0_ready = (state_q == GNT0) && out_free;
  assign req1_ready = (state_q == GNT1) && out_free;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant    = grant_q;

  always_comb begin
    own_id      = (state_q == GNT1);
    own_valid   = own_id ? req1_valid : req0_valid;
    other_valid = own_id ? req0_valid : req1_valid;
    other_state = own_id ? GNT0 : GNT1;
    own_hs      = hs0 || hs1;
    cnt_inc     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (hs0) begin
      tx_data_d  = req0_data;
      tx_valid_d = 1'b1;
    end else if (hs1) begin
      tx_data_d  = req1_data;
      tx_valid_d = 1'b1;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that was not served last wins.
        if (req0_valid && (!req1_valid || last_q)) begin
          state_d = GNT0;
        end else if (req1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!own_valid) begin
          state_d = other_valid ? other_state : IDLE;
          last_d  = own_id;
        end else if (other_valid && ((own_hs ? cnt_inc : cnt_q) == CNT_MAX)) begin
          state_d = other_state;
          last_d  = own_id;
        end else if (own_hs) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cnt_q      <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= {state_d == GNT1, state_d == GNT0};
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level owner/burst model and a byte FIFO.
module tb_uart_tx_arbiter;

  localparam int BM = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] req0_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [1:0] grant;

  uart_tx_arbiter #(.BURST_MAX(BM)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0_data (req0_data),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req1_data (req1_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: owner -1 = nobody, 0/1 = requester index.
  int         m_owner, m_last, m_cnt;
  bit         m_txv;
  logic [7:0] m_txd;
  logic [7:0] exp_q[$];
  bit         src_log[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    m_txv   = 1'b0;
    m_txd   = 8'h00;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_grant"}, 32'(grant), 32'(0));
    check_val({tag, "_tx_valid"}, 32'(tx_valid), 32'(0));
    check_val({tag, "_tx_data"}, 32'(tx_data), 32'(0));
    check_val({tag, "_ready0"}, 32'(req0_ready), 32'(0));
    check_val({tag, "_ready1"}, 32'(req1_ready), 32'(0));
  endtask

  // Called at posedge+1; applies one cycle of inputs and advances to next posedge+1.
  task automatic step(input bit v0, input logic [7:0] d0, input bit v1,
                      input logic [7:0] d1, input bit tr);
    logic [1:0] eg;
    logic [7:0] head;
    bit r0, r1, h0, h1, ov, tv, oh;
    int nw, own, oth, c;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    check_val("grant", 32'(grant), 32'(eg));
    check_val("tx_valid", 32'(tx_valid), 32'(m_txv));
    check_val("tx_data", 32'(tx_data), 32'(m_txd));
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    tx_ready   = tr;
    #1;
    r0 = (m_owner == 0) && (!m_txv || tr);
    r1 = (m_owner == 1) && (!m_txv || tr);
    check_val("req0_ready", 32'(req0_ready), 32'(r0));
    check_val("req1_ready", 32'(req1_ready), 32'(r1));
    h0 = v0 && r0;
    h1 = v1 && r1;
    if (m_txv && tr) begin
      head = exp_q.pop_front();
      check_val("tx_order", 32'(tx_data), 32'(head));
      src_log.push_back(tx_data[7]);
    end
    if (h0) exp_q.push_back(d0);
    if (h1) exp_q.push_back(d1);
    if (h0 || h1) begin
      m_txv = 1'b1;
      m_txd = h0 ? d0 : d1;
    end else if (tr) begin
      m_txv = 1'b0;
    end
    nw = m_owner;
    if (m_owner < 0) begin
      if (v0 && v1) nw = (m_last == 1) ? 0 : 1;
      else if (v0) nw = 0;
      else if (v1) nw = 1;
    end else begin
      own = m_owner;
      oth = 1 - own;
      ov  = (own == 0) ? v0 : v1;
      tv  = (own == 0) ? v1 : v0;
      oh  = (own == 0) ? h0 : h1;
      if (!ov) begin
        nw = tv ? oth : -1;
        m_last = own;
      end else begin
        c = oh ? ((m_cnt + 1 > BM) ? BM : m_cnt + 1) : m_cnt;
        if (tv && c == BM) begin
          nw = oth;
          m_last = own;
        end else begin
          m_cnt = c;
        end
      end
    end
    if (nw != m_owner) m_cnt = 0;
    m_owner = nw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  // Asynchronous reset asserted mid-cycle, held 3 cycles, released away from the edge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs(tag);
    end
    #2;
    reset_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge clk);
    #1;
    do_reset("por2");

    // Single byte from requester 0.
    step(1'b1, 8'h7A, 1'b0, 8'h00, 1'b1);
    idle(4);

    // Tie from reset: expect bursts 0,0,0,0,1,1,1,1,0,...
    do_reset("tie_rst");
    src_log.delete();
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'($urandom_range(0, 127)), 1'b1, 8'($urandom_range(128, 255)), 1'b1);
    idle(3);
    for (int i = 0; i < 12; i++)
      check_val("tie_src", (i < src_log.size()) ? 32'(src_log[i]) : 32'hEE, 32'((i / 4) % 2));

    // Backpressure: 10 stalled cycles with a byte pending, then drain.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h90 + i), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h20, 1'b1, 8'hA0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 8'(8'hB0 + i), 1'b1);
    idle(3);

    // Solo burst on requester 1; requester 0 joins at byte 6.
    for (int i = 0; i < 10; i++) step(i >= 5, 8'(8'h40 + i), 1'b1, 8'(8'hC0 + i), 1'b1);
    idle(3);

    // Gap: requester 0 drops valid for one cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h58 + i), 1'b0, 8'h00, 1'b1);
    idle(3);

    // Reset mid-burst with a byte stuck in the output register.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 8'(8'hE0 + i), 1'b0);
    do_reset("mid_rst");
    idle(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 127)),
           $urandom_range(0, 3) != 0, 8'($urandom_range(128, 255)),
           $urandom_range(0, 2) != 0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
